piso: RTL

- Parallel-in serial-out transmitter, the transmit end of the serial link whose receive end is the sipo block.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled cycle on a single serial line.
- Provides per-bit valid and end-of-word markers so a downstream sipo (or checker) can frame words.
- Supports back-to-back words with no idle bit between them.

---
 rtl/piso.sv | 87 ++++++++
 1 files changed

// File: rtl/piso.sv
// piso: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per enabled cycle, with per-bit valid and end-of-word markers so the
// receiving sipo can frame words. Back-to-back words leave no idle bit.
module piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial,
    output logic             serial_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic cntZero;
    logic loadFire;

    assign cntZero  = (cnt_q == '0);
    assign busy     = (state_q == SHIFT);
    assign last     = busy & cntZero;

    // The bit strobe on the final bit frees the shifter for the next word in
    // the same edge, which is what gives zero-gap back-to-back transfers.
    assign load_ready   = (state_q == IDLE) | (busy & cntZero & en);
    assign serial_valid = busy & en;
    assign loadFire     = load_valid & load_ready;

    // The output end of the shifter drives the line; gated by busy so the
    // line rests at 0 while idle whatever the shifter holds.
    assign serial = busy & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

    // Next-state logic: load on a handshake, otherwise advance one bit per
    // enabled cycle and drop back to IDLE once the final bit has gone out.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (loadFire) begin
            state_d = SHIFT;
            shreg_d = par_in;
            cnt_d   = CW'(WIDTH - 1);
        end else if (busy && en) begin
            if (!cntZero) begin
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IDLE;
                shreg_d = '0;
            end
        end
    end

    // State registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
